// File: rtl/spr_scoreboard_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : spr_scoreboard_multi_if
//  Description : Decode/issue/retire bundle and ready/error outputs of the
//                multi-retire SPR scoreboard. Flush signals exist only when
//                SPR_SCOREBOARD_FLUSH_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spr_scoreboard_multi_if #(
    parameter int NUM_WF    = 40,
    parameter int WFID_W    = 6,
    parameter int NUM_SPR   = 4,
    parameter int RET_PORTS = 2
);
    logic                          decode_valid;
    logic [WFID_W-1:0]             decode_wfid;
    logic [NUM_SPR-1:0]            decode_dep_mask;
    logic                          issue_valid;
    logic [WFID_W-1:0]             issue_wfid;
    logic [NUM_SPR-1:0]            issue_wr_mask;
    logic [RET_PORTS-1:0]          retire_valid;
    logic [RET_PORTS*WFID_W-1:0]   retire_wfid;
    logic [RET_PORTS*NUM_SPR-1:0]  retire_wr_mask;
`ifdef SPR_SCOREBOARD_FLUSH_EN
    logic                          flush_valid;
    logic [WFID_W-1:0]             flush_wfid;
`endif
    logic [NUM_WF-1:0]             ready_arry_spr;
    logic                          err_overflow;
    logic                          err_underflow;

    modport master (
        output decode_valid, decode_wfid, decode_dep_mask,
        output issue_valid, issue_wfid, issue_wr_mask,
        output retire_valid, retire_wfid, retire_wr_mask,
`ifdef SPR_SCOREBOARD_FLUSH_EN
        output flush_valid, flush_wfid,
`endif
        input  ready_arry_spr, err_overflow, err_underflow
    );

    modport slave (
        input  decode_valid, decode_wfid, decode_dep_mask,
        input  issue_valid, issue_wfid, issue_wr_mask,
        input  retire_valid, retire_wfid, retire_wr_mask,
`ifdef SPR_SCOREBOARD_FLUSH_EN
        input  flush_valid, flush_wfid,
`endif
        output ready_arry_spr, err_overflow, err_underflow
    );
endinterface
`default_nettype wire

// File: rtl/spr_scoreboard_multi.sv
`default_nettype none
// ============================================================================
//  Module      : spr_scoreboard_multi
//  Description : Per-wavefront SPR hazard scoreboard with saturating in-flight
//                counters, RET_PORTS retire channels and a registered ready
//                vector. Optional flush via SPR_SCOREBOARD_FLUSH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module spr_scoreboard_multi #(
    parameter int NUM_WF    = 40,
    parameter int WFID_W    = 6,
    parameter int NUM_SPR   = 4,
    parameter int CNT_W     = 2,
    parameter int RET_PORTS = 2
) (
    input  wire                      clk,
    input  wire                      rst,
    spr_scoreboard_multi_if.slave    bus
);
    localparam int C_CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0]   cnt_q [NUM_WF][NUM_SPR];
    logic [CNT_W-1:0]   cnt_d [NUM_WF][NUM_SPR];
    logic [NUM_SPR-1:0] dep_q [NUM_WF];
    logic [NUM_SPR-1:0] dep_d [NUM_WF];
    logic [NUM_WF-1:0]  ready_q, ready_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    always_comb begin
        logic [NUM_SPR-1:0] dep_eff;
        logic [NUM_SPR-1:0] busy;
        logic               flush_hit;
        int                 inc;
        int                 dec;
        int                 sum;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ready_d = ready_q;
        for (int w = 0; w < NUM_WF; w++) begin
            flush_hit = 1'b0;
`ifdef SPR_SCOREBOARD_FLUSH_EN
            flush_hit = bus.flush_valid && (bus.flush_wfid == WFID_W'(w));
`endif
            dep_eff = (bus.decode_valid && (bus.decode_wfid == WFID_W'(w)))
                      ? bus.decode_dep_mask : dep_q[w];
            busy = '0;
            for (int s = 0; s < NUM_SPR; s++) begin
                inc = (bus.issue_valid && (bus.issue_wfid == WFID_W'(w))
                       && bus.issue_wr_mask[s]) ? 1 : 0;
                dec = 0;
                for (int k = 0; k < RET_PORTS; k++) begin
                    if (bus.retire_valid[k]
                        && (bus.retire_wfid[k*WFID_W +: WFID_W] == WFID_W'(w))
                        && bus.retire_wr_mask[k*NUM_SPR + s])
                        dec = dec + 1;
                end
                sum = int'(cnt_q[w][s]) + inc - dec;
                // Flush wins: the entry is wiped and its errors are suppressed.
                if (flush_hit) begin
                    sum = 0;
                end else if (sum > C_CNT_MAX) begin
                    sum   = C_CNT_MAX;
                    ovf_d = 1'b1;
                end else if (sum < 0) begin
                    sum   = 0;
                    unf_d = 1'b1;
                end
                cnt_d[w][s] = CNT_W'(sum);
                busy[s]     = (sum != 0);
            end
            if (flush_hit)
                dep_eff = '0;
            dep_d[w]   = dep_eff;
            ready_d[w] = ~|(dep_eff & busy);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < NUM_WF; w++) begin
                dep_q[w] <= '0;
                for (int s = 0; s < NUM_SPR; s++)
                    cnt_q[w][s] <= '0;
            end
            ready_q <= '1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WF; w++) begin
                dep_q[w] <= dep_d[w];
                for (int s = 0; s < NUM_SPR; s++)
                    cnt_q[w][s] <= cnt_d[w][s];
            end
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.ready_arry_spr = ready_q;
    assign bus.err_overflow   = ovf_q;
    assign bus.err_underflow  = unf_q;

endmodule
`default_nettype wire
